// File: rtl/mini_alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu_pipe_pkg
// Description : Shared definitions for the mini ALU pipeline. This package
//               holds the opcode encoding, the instruction field layout
//               (derived from the register-address width), the NOP encoding
//               and a decode helper.
//               There are no ports; the package is imported by the interface
//               and by the modules.
// Revision    : 1.0 - initial two-stage pipelined release
// ============================================================================
package mini_alu_pipe_pkg;

    localparam int c_OP_WIDTH = 4;

    typedef enum logic [c_OP_WIDTH-1:0] {
        c_OP_NOP   = 4'd0,
        c_OP_LED   = 4'd1,
        c_OP_BLE   = 4'd2,
        c_OP_STO   = 4'd3,
        c_OP_ADD   = 4'd4,
        c_OP_JMP   = 4'd5,
        c_OP_SUB   = 4'd6,
        c_OP_SMUL  = 4'd7,
        c_OP_SHL   = 4'd8,
        c_OP_SHR   = 4'd9,
        c_OP_AND   = 4'd10,
        c_OP_OR    = 4'd11,
        c_OP_BEQ   = 4'd12,
        c_OP_HLT   = 4'd13,
        c_OP_RSV14 = 4'd14,
        c_OP_RSV15 = 4'd15
    } opcode_e;

    // Instruction layout: {op, dst, src1, src0}. Each address field is aw bits wide.
    function automatic int instrWidth(input int aw);
        return c_OP_WIDTH + 3 * aw;
    endfunction

    function automatic int src0Lsb(input int aw);
        return 0 * aw;
    endfunction

    function automatic int src1Lsb(input int aw);
        return 1 * aw;
    endfunction

    function automatic int dstLsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int opLsb(input int aw);
        return 3 * aw;
    endfunction

    // These are the ops that commit a result to the register file. They are
    // also the only ops whose result may be forwarded.
    function automatic logic writesReg(input opcode_e op);
        case (op)
            c_OP_STO, c_OP_ADD, c_OP_SUB, c_OP_SMUL,
            c_OP_SHL, c_OP_SHR, c_OP_AND, c_OP_OR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mini_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu_pipe_if
// Description : Bus between the mini ALU pipeline and its environment, which
//               is the instruction ROM, the stall control and the LED/halt
//               observers.
//   iEnable      : environment -> core, advance (1) or freeze (0)
//   iInstruction : ROM -> core, {op, dst, src1, src0} at address oIP
//   oIP          : core -> ROM, fetch address
//   oLed         : core -> board, registered LED value
//   oHalted      : core -> board, high once HLT has executed
// Modports    : master = core side, slave = environment side
// Revision    : 1.0 - initial two-stage pipelined release
// ============================================================================
interface mini_alu_pipe_if
    import mini_alu_pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int IP_WIDTH   = 16,
    parameter int LED_WIDTH  = 8
);
    logic                             iEnable;
    logic [instrWidth(ADDR_WIDTH)-1:0] iInstruction;
    logic [IP_WIDTH-1:0]              oIP;
    logic [LED_WIDTH-1:0]             oLed;
    logic                             oHalted;

    modport master (
        input  iEnable,
        input  iInstruction,
        output oIP,
        output oLed,
        output oHalted
    );

    modport slave (
        output iEnable,
        output iInstruction,
        input  oIP,
        input  oLed,
        input  oHalted
    );
endinterface
`default_nettype wire

// File: rtl/mini_alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu_regfile
// Description : Register file with 2**ADDR_WIDTH entries. It has two
//               synchronous read ports and one synchronous write port. When a
//               read and a write hit the same address on the same edge, the
//               read returns the old contents. The pipeline's bypass path
//               supplies the new value in that case.
// Ports       :
//   clk                  : clock
//   i_rdEn               : capture new read data (0 holds the read registers)
//   i_rdAddr0/1          : read addresses
//   o_rdData0/1          : registered read data
//   i_wrEn/Addr/Data     : write port
// Revision    : 1.0 - initial release
// ============================================================================
module mini_alu_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  i_rdEn,
    input  wire logic [ADDR_WIDTH-1:0] i_rdAddr0,
    input  wire logic [ADDR_WIDTH-1:0] i_rdAddr1,
    output logic      [DATA_WIDTH-1:0] o_rdData0,
    output logic      [DATA_WIDTH-1:0] o_rdData1,
    input  wire logic                  i_wrEn,
    input  wire logic [ADDR_WIDTH-1:0] i_wrAddr,
    input  wire logic [DATA_WIDTH-1:0] i_wrData
);
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdData0;
    logic [DATA_WIDTH-1:0] r_rdData1;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_rdEn) begin
            r_rdData0 <= r_mem[i_rdAddr0];
            r_rdData1 <= r_mem[i_rdAddr1];
        end
    end

    assign o_rdData0 = r_rdData0;
    assign o_rdData1 = r_rdData1;

endmodule
`default_nettype wire

// File: rtl/mini_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mini_alu_pipe
// Description : Two-stage (fetch / execute) mini ALU core.
//               F: presents oIP to the ROM and latches the instruction into
//                  X. The register file read for src0/src1 is issued in the
//                  same cycle.
//               X: executes the instruction. It writes the result, updates
//                  the LED and resolves branches and HLT. A taken branch or
//                  HLT turns the instruction currently in F into a NOP.
// Ports       :
//   Clock        : clock, all state on the rising edge
//   Reset        : synchronous, active-high
//   bus.iEnable  : 1 advances the pipeline, 0 freezes all state
//   bus.iInstruction / bus.oIP : ROM fetch interface
//   bus.oLed     : registered LED value
//   bus.oHalted  : high after HLT until Reset
// Revision    : 1.0 - initial two-stage pipelined release
// ============================================================================
module mini_alu_pipe
    import mini_alu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IP_WIDTH   = 16,
    parameter int LED_WIDTH  = 8
) (
    input  wire logic       Clock,
    input  wire logic       Reset,
    mini_alu_pipe_if.master bus
);
    localparam int c_INSTR_W  = instrWidth(ADDR_WIDTH);
    localparam int c_SRC0_LSB = src0Lsb(ADDR_WIDTH);
    localparam int c_SRC1_LSB = src1Lsb(ADDR_WIDTH);
    localparam int c_DST_LSB  = dstLsb(ADDR_WIDTH);
    localparam int c_OP_LSB   = opLsb(ADDR_WIDTH);
    localparam int c_SHAMT_W  = $clog2(DATA_WIDTH);
    localparam logic [c_INSTR_W-1:0] c_NOP_INSTR = {c_OP_NOP, {(3 * ADDR_WIDTH){1'b0}}};

    // Pipeline state
    logic [IP_WIDTH-1:0]   r_ip;
    logic [c_INSTR_W-1:0]  r_xInstr;
    logic [LED_WIDTH-1:0]  r_led;
    logic                  r_halted;
    // Record of the instruction that retired on the previous advancing edge
    logic                  r_fwdValid;
    logic [ADDR_WIDTH-1:0] r_fwdDst;
    logic [DATA_WIDTH-1:0] r_fwdData;

    // X-stage decode
    opcode_e               w_xOp;
    logic [ADDR_WIDTH-1:0] w_xDst;
    logic [ADDR_WIDTH-1:0] w_xSrc1;
    logic [ADDR_WIDTH-1:0] w_xSrc0;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [IP_WIDTH-1:0]   w_target;

    // Operands and results
    logic [DATA_WIDTH-1:0] w_rf0;
    logic [DATA_WIDTH-1:0] w_rf1;
    logic [DATA_WIDTH-1:0] w_op0;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_writes;
    logic                  w_branch;
    logic                  w_ledWe;
    logic                  w_halt;
    logic                  w_squash;
    logic                  w_rfWe;

    assign w_xOp    = opcode_e'(r_xInstr[c_OP_LSB +: c_OP_WIDTH]);
    assign w_xDst   = r_xInstr[c_DST_LSB  +: ADDR_WIDTH];
    assign w_xSrc1  = r_xInstr[c_SRC1_LSB +: ADDR_WIDTH];
    assign w_xSrc0  = r_xInstr[c_SRC0_LSB +: ADDR_WIDTH];
    // The size cast zero-extends or truncates {src1,src0} to the datapath width
    assign w_imm    = DATA_WIDTH'({w_xSrc1, w_xSrc0});
    assign w_target = IP_WIDTH'(w_xDst);

    mini_alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk       (Clock),
        .i_rdEn    (bus.iEnable),
        .i_rdAddr0 (bus.iInstruction[c_SRC0_LSB +: ADDR_WIDTH]),
        .i_rdAddr1 (bus.iInstruction[c_SRC1_LSB +: ADDR_WIDTH]),
        .o_rdData0 (w_rf0),
        .o_rdData1 (w_rf1),
        .i_wrEn    (w_rfWe),
        .i_wrAddr  (w_xDst),
        .i_wrData  (w_result)
    );

    // The register file read happened on the same edge as the previous
    // instruction's write, so it returned the old value. The forwarding
    // record supplies the new value.
    assign w_op0 = (r_fwdValid && (r_fwdDst == w_xSrc0)) ? r_fwdData : w_rf0;
    assign w_op1 = (r_fwdValid && (r_fwdDst == w_xSrc1)) ? r_fwdData : w_rf1;

    always_comb begin
        w_result = '0;
        w_branch = 1'b0;
        w_ledWe  = 1'b0;
        w_halt   = 1'b0;
        case (w_xOp)
            c_OP_LED:  w_ledWe  = 1'b1;
            c_OP_BLE:  w_branch = (w_op1 <= w_op0);
            c_OP_STO:  w_result = w_imm;
            c_OP_ADD:  w_result = w_op1 + w_op0;
            c_OP_JMP:  w_branch = 1'b1;
            c_OP_SUB:  w_result = w_op0 - w_op1;
            // The low half of a product is the same for signed and unsigned operands
            c_OP_SMUL: w_result = w_op0 * w_op1;
            c_OP_SHL:  w_result = w_op0 << w_op1[c_SHAMT_W-1:0];
            c_OP_SHR:  w_result = w_op0 >> w_op1[c_SHAMT_W-1:0];
            c_OP_AND:  w_result = w_op0 & w_op1;
            c_OP_OR:   w_result = w_op0 | w_op1;
            c_OP_BEQ:  w_branch = (w_op1 == w_op0);
            c_OP_HLT:  w_halt   = 1'b1;
            default:   ;
        endcase
    end

    assign w_writes = writesReg(w_xOp);
    assign w_rfWe   = bus.iEnable & ~Reset & w_writes;
    // Once halted, every fetch is discarded so X stays a NOP until Reset
    assign w_squash = w_branch | w_halt | r_halted;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ip       <= '0;
            r_xInstr   <= c_NOP_INSTR;
            r_led      <= '0;
            r_halted   <= 1'b0;
            r_fwdValid <= 1'b0;
            r_fwdDst   <= '0;
            r_fwdData  <= '0;
        end else if (bus.iEnable) begin
            r_xInstr <= w_squash ? c_NOP_INSTR : bus.iInstruction;

            if (w_branch) begin
                r_ip <= w_target;
            end else if (!(w_halt || r_halted)) begin
                r_ip <= r_ip + IP_WIDTH'(1);
            end

            if (w_halt) begin
                r_halted <= 1'b1;
            end

            if (w_ledWe) begin
                r_led <= w_op1[LED_WIDTH-1:0];
            end

            r_fwdValid <= w_writes;
            r_fwdDst   <= w_xDst;
            r_fwdData  <= w_result;
        end
    end

    assign bus.oIP     = r_ip;
    assign bus.oLed    = r_led;
    assign bus.oHalted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_alu_pipe
// Description : Self-checking bench for mini_alu_pipe. It contains an ALU
//               vector table, hand-written pipeline corner sequences and
//               random forward-branching programs with random stalls. The
//               random programs are checked against an instruction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_alu_pipe;
    localparam int c_DW  = 16;
    localparam int c_AW  = 8;
    localparam int c_IPW = 8;
    localparam int c_LW  = 8;
    localparam logic [27:0] c_HLT = {4'd13, 24'd0};

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    logic [27:0] rom [256];
    logic [7:0]  ipAt  [64];
    logic [7:0]  ledAt [64];
    logic        hAt   [64];
    logic [7:0]  expLed [$];
    logic [7:0]  dutLed [$];

    mini_alu_pipe_if #(.ADDR_WIDTH(c_AW), .IP_WIDTH(c_IPW), .LED_WIDTH(c_LW)) bus ();

    mini_alu_pipe #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW),
        .IP_WIDTH   (c_IPW),
        .LED_WIDTH  (c_LW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.iInstruction = rom[bus.oIP];

    always #5 Clock = ~Clock;

    task automatic check(input string name, input longint act, input longint exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] ins(input int op, input int d, input int s1, input int s0);
        return {op[3:0], d[7:0], s1[7:0], s0[7:0]};
    endfunction

    function automatic logic [27:0] sto(input int d, input logic [15:0] imm);
        return {4'd3, d[7:0], imm};
    endfunction

    task automatic clearRom(input logic [27:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    task automatic stepEdge();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        bus.iEnable = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // After doReset, index e holds the outputs seen just after edge e
    task automatic runRecord(input int n);
        for (int e = 0; e < n; e++) begin
            stepEdge();
            ipAt[e]  = bus.oIP;
            ledAt[e] = bus.oLed;
            hAt[e]   = bus.oHalted;
        end
    endtask

    // Instruction-level reference: each instruction completes before the next
    // starts. Every executed instruction costs one cycle and a taken branch
    // costs one more. HLT becomes visible two edges after it is fetched.
    task automatic modelRun(output int expEdges, output int expIp);
        logic [15:0] regs [256];
        logic [7:0]  led;
        int pc, cyc;
        expLed.delete();
        led = 8'd0;
        for (int i = 0; i < 256; i++) regs[i] = 16'd0;
        pc = 0;
        cyc = 0;
        expEdges = -1;
        expIp = -1;
        for (int n = 0; n < 1000; n++) begin
            logic [27:0] w;
            int op, d, s1, s0, a, b, nxt;
            longint pa, pb;
            w  = rom[pc];
            op = int'(w[27:24]);
            d  = int'(w[23:16]);
            s1 = int'(w[15:8]);
            s0 = int'(w[7:0]);
            a  = int'(regs[s0]);
            b  = int'(regs[s1]);
            nxt = (pc + 1) % 256;
            if (op == 13) begin
                expEdges = cyc + 2;
                expIp = (pc + 1) % 256;
                break;
            end
            case (op)
                1: if (regs[s1][7:0] != led) begin
                       led = regs[s1][7:0];
                       expLed.push_back(led);
                   end
                2: if (b <= a) begin nxt = d; cyc++; end
                3: regs[d] = w[15:0];
                4: regs[d] = 16'((a + b) & 'hFFFF);
                5: begin nxt = d; cyc++; end
                6: regs[d] = 16'((a - b) & 'hFFFF);
                7: begin
                       pa = longint'($signed(regs[s0]));
                       pb = longint'($signed(regs[s1]));
                       regs[d] = 16'((pa * pb) & 'hFFFF);
                   end
                8: regs[d] = 16'((a << (b % 16)) & 'hFFFF);
                9: regs[d] = 16'(a >> (b % 16));
                10: regs[d] = 16'(a & b);
                11: regs[d] = 16'(a | b);
                12: if (a == b) begin nxt = d; cyc++; end
                default: ;
            endcase
            cyc++;
            pc = nxt;
        end
    endtask

    // Registers 0..7 are preset first. Every branch target points forward and
    // address 40 onward is HLT, so every program terminates.
    task automatic genProgram();
        clearRom(c_HLT);
        for (int r = 0; r < 8; r++) rom[r] = sto(r, 16'($urandom));
        for (int a = 8; a < 40; a++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if (op == 13) op = 4;
            if (op == 2 || op == 5 || op == 12)
                rom[a] = ins(op, int'($urandom_range(a + 1, 40)),
                             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else if (op == 3)
                rom[a] = sto(int'($urandom_range(0, 7)), 16'($urandom));
            else
                rom[a] = ins(op, int'($urandom_range(0, 7)),
                             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
    endtask

    typedef struct {
        string       name;
        int          op;
        logic [15:0] a;    // src1 operand
        logic [15:0] b;    // src0 operand
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{"add_5_7",       4, 16'h0005, 16'h0007, 16'h000C};
        vecs[1]  = '{"add_wrap",      4, 16'hFFFF, 16'h0002, 16'h0001};
        vecs[2]  = '{"sub_self",      6, 16'h0003, 16'h0003, 16'h0000};
        vecs[3]  = '{"sub_under",     6, 16'h0001, 16'h0000, 16'hFFFF};
        vecs[4]  = '{"smul_neg",      7, 16'hFFFF, 16'h0002, 16'hFFFE};
        vecs[5]  = '{"smul_pos",      7, 16'h0123, 16'h0010, 16'h1230};
        vecs[6]  = '{"smul_minmin",   7, 16'h8000, 16'hFFFF, 16'h8000};
        vecs[7]  = '{"shl_4",         8, 16'h0004, 16'h1234, 16'h2340};
        vecs[8]  = '{"shl_lowbits",   8, 16'h0013, 16'h0001, 16'h0008};
        vecs[9]  = '{"shr_4",         9, 16'h0004, 16'h8421, 16'h0842};
        vecs[10] = '{"shr_15",        9, 16'h001F, 16'h8000, 16'h0001};
        vecs[11] = '{"and",          10, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[12] = '{"or",           11, 16'h00F0, 16'h0F00, 16'h0FF0};

        bus.iEnable = 1'b1;
        clearRom(c_HLT);

        // Reset state
        doReset();
        check("reset_ip", bus.oIP, 0);
        check("reset_led", bus.oLed, 0);
        check("reset_halted", bus.oHalted, 0);

        // ALU table. r3 = op(src1=r1, src0=r2) is forwarded. The LED shows the
        // high byte (r3 >> 8) and then the low byte.
        for (int v = 0; v < 13; v++) begin
            clearRom(c_HLT);
            rom[0] = sto(1, vecs[v].a);
            rom[1] = sto(2, vecs[v].b);
            rom[2] = ins(vecs[v].op, 3, 1, 2);
            rom[3] = sto(4, 16'd8);
            rom[4] = ins(9, 5, 4, 3);
            rom[5] = ins(1, 0, 5, 0);
            rom[6] = ins(1, 0, 3, 0);
            doReset();
            runRecord(10);
            check(vecs[v].name, {ledAt[6], ledAt[7]}, vecs[v].exp);
            check({vecs[v].name, "_halt"}, {hAt[7], hAt[8]}, 2'b01);
        end

        // Taken BLE squashes the fall-through STO r5
        clearRom(c_HLT);
        rom[0] = sto(5, 16'h0055);
        rom[1] = sto(1, 16'd2);
        rom[2] = sto(2, 16'd2);
        rom[3] = ins(2, 8'h20, 1, 2);
        rom[4] = sto(5, 16'h00AA);
        rom[8'h20] = ins(1, 0, 5, 0);
        doReset();
        runRecord(10);
        check("ble_no_bubble_before", ipAt[3], 4);
        check("ble_target", ipAt[4], 8'h20);
        check("ble_after_target", ipAt[5], 8'h21);
        check("ble_squash_led", ledAt[6], 8'h55);

        // BEQ not taken falls through; JMP 0xFF wraps to 0
        clearRom(ins(0, 0, 0, 0));
        rom[0] = sto(1, 16'd1);
        rom[1] = sto(2, 16'd2);
        rom[2] = ins(12, 8'h30, 1, 2);
        rom[4] = ins(5, 8'hFF, 0, 0);
        doReset();
        runRecord(8);
        check("beq_fallthrough", ipAt[3], 4);
        check("beq_no_bubble", ipAt[4], 5);
        check("jmp_target", ipAt[5], 8'hFF);
        check("ip_wrap", ipAt[6], 8'h00);

        // HLT at address 9; the LED op at address 10 must never run
        clearRom(ins(0, 0, 0, 0));
        rom[0] = sto(1, 16'h0033);
        rom[1] = ins(1, 0, 1, 0);
        rom[2] = sto(2, 16'h0044);
        rom[9] = c_HLT;
        rom[10] = ins(1, 0, 2, 0);
        doReset();
        runRecord(25);
        check("hlt_not_yet", hAt[9], 0);
        check("hlt_set", hAt[10], 1);
        check("hlt_ip", ipAt[10], 10);
        check("hlt_ip_frozen", ipAt[24], 10);
        check("hlt_led_kept", ledAt[24], 8'h33);
        check("hlt_stays", hAt[24], 1);

        // Three stalled cycles between dependent STO and ADD
        begin
            int budget;
            clearRom(c_HLT);
            rom[0] = sto(1, 16'd9);
            rom[1] = sto(2, 16'd4);
            rom[2] = ins(4, 3, 1, 2);
            rom[3] = ins(1, 0, 3, 0);
            doReset();
            stepEdge();
            stepEdge();
            bus.iEnable = 1'b0;
            repeat (3) stepEdge();
            check("stall_ip_held", bus.oIP, 2);
            bus.iEnable = 1'b1;
            budget = 0;
            while (!bus.oHalted && budget < 20) begin
                stepEdge();
                budget++;
            end
            check("stall_halted", bus.oHalted, 1);
            check("stall_add_led", bus.oLed, 8'h0D);
        end

        // Reset during a taken JMP, with iEnable low
        clearRom(c_HLT);
        rom[0] = sto(1, 16'h0021);
        rom[1] = ins(1, 0, 1, 0);
        rom[2] = ins(5, 8'h40, 0, 0);
        doReset();
        repeat (3) stepEdge();
        check("pre_reset_led", bus.oLed, 8'h21);
        Reset = 1'b1;
        bus.iEnable = 1'b0;
        stepEdge();
        Reset = 1'b0;
        bus.iEnable = 1'b1;
        check("midreset_ip", bus.oIP, 0);
        check("midreset_led", bus.oLed, 0);
        check("midreset_halted", bus.oHalted, 0);
        stepEdge();
        check("midreset_restart", bus.oIP, 1);

        // Random programs with random stalls against the reference model
        for (int p = 0; p < 40; p++) begin
            int expEdges, expIp, edges;
            logic halted, en;
            logic [7:0] last;
            genProgram();
            modelRun(expEdges, expIp);
            doReset();
            dutLed.delete();
            last = 8'd0;
            edges = 0;
            halted = 1'b0;
            for (int c = 0; c < 600 && !halted; c++) begin
                en = ($urandom_range(0, 9) < 8);
                bus.iEnable = en;
                stepEdge();
                if (en) edges++;
                if (bus.oLed != last) begin
                    last = bus.oLed;
                    dutLed.push_back(last);
                end
                halted = bus.oHalted;
            end
            bus.iEnable = 1'b1;
            check($sformatf("rnd%0d_halted", p), halted, 1);
            check($sformatf("rnd%0d_edges", p), edges, expEdges);
            check($sformatf("rnd%0d_ip", p), bus.oIP, expIp);
            check($sformatf("rnd%0d_ledcount", p), dutLed.size(), expLed.size());
            for (int i = 0; i < expLed.size() && i < dutLed.size(); i++)
                check($sformatf("rnd%0d_led%0d", p, i), dutLed[i], expLed[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mini_alu_pipe.md
Name: mini_alu_pipe

Overview:
Parametrised two-stage (fetch/execute) successor of the team's mini ALU core, for FPGA lab boards.
- Fetches instructions from an external combinational ROM through oIP/iInstruction.
- Executes on an internal register file, with a correct result-forwarding path and registered branch redirect plus squash.
- Adds stall, halt, an extended opcode set and a generic-width LED port.

Parameters:
DATA_WIDTH, 16, datapath and register width
ADDR_WIDTH, 8, register-address field width; register file depth = 2**ADDR_WIDTH
IP_WIDTH, 16, instruction pointer width
LED_WIDTH, 8, LED output width (LED_WIDTH <= DATA_WIDTH)

Ports:
Clock  in  1  single clock, all state on rising edge
Reset  in  1  synchronous, active-high
iEnable  in  1  1 = advance pipeline; 0 = freeze all state (IP, X stage, reg file writes, LED)
oIP  out  IP_WIDTH  fetch address to instruction ROM
iInstruction  in  4+3*ADDR_WIDTH  {op[3:0], dst, src1, src0}, valid in the cycle oIP is presented
oLed  out  LED_WIDTH  registered LED value
oHalted  out  1  high after HLT executes, until Reset

Behaviour:
- Reset state:
  - oIP=0, oLed=0, oHalted=0.
  - X stage holds NOP; forwarding-valid flag cleared.
  - Register file contents are not reset.
- Fetch (F):
  - In the cycle oIP=A, iInstruction is latched into the X register at the edge.
  - Register file synchronous read is issued with src0/src1 in the same cycle.
  - Next IP is A+1, wrapping modulo 2**IP_WIDTH.
- Execute (X): one cycle. Result is written at the end of the X cycle when the op writes. Latency is fetch-to-writeback = 2 edges.
- Immediate: {src1,src0} zero-extended or truncated to DATA_WIDTH.
- Opcodes (shared constants):
  - NOP=0
  - LED=1: oLed <= src1 data[LED_WIDTH-1:0]
  - BLE=2: branch to dst if src1 <= src0, unsigned
  - STO=3: dst <= imm
  - ADD=4: src1 + src0
  - JMP=5: branch to dst unconditionally
  - SUB=6: src0 - src1
  - SMUL=7: low DATA_WIDTH bits of the signed product
  - SHL=8 / SHR=9: src0 shifted logically by src1[$clog2(DATA_WIDTH)-1:0]
  - AND=10, OR=11
  - BEQ=12: branch to dst if src1 == src0
  - HLT=13
  - 14 and 15: treated as NOP. No write, no LED update. This differs from the previous core, which updated LED on unknown opcodes.
- Arithmetic: all results are modulo 2**DATA_WIDTH.
- Branch target: dst zero-extended to IP_WIDTH.
- Writing ops: STO, ADD, SUB, SMUL, SHL, SHR, AND, OR.
- Forwarding:
  - An operand uses the previous X result instead of the register file output when all hold:
    - the previous X op was a writing op;
    - it was not squashed;
    - its dst equals the operand's source address.
  - Both operands may forward simultaneously.
  - Non-writing ops never forward.
- Branch taken (in X):
  - IP <= target at the edge.
  - The instruction currently in F is squashed into X as NOP: no write, no LED, no branch, no forward.
  - Penalty is 1 cycle.
  - Branch not taken: no penalty.
- HLT:
  - At the edge, oHalted <= 1.
  - IP freezes at HLT address + 1.
  - The instruction in F is squashed.
  - Thereafter X holds NOP until Reset.
- iEnable=0: every register holds, including the forwarding record. When resumed, behaviour is identical to an unstalled run.
- Reset mid-operation wins over everything: branch, HLT, iEnable=0. The next cycle presents oIP=0.

Decomposition:
- Shared package/definitions file: opcode constants, field offsets derived from ADDR_WIDTH, NOP encoding.
- One sub-module, mini_alu_regfile:
  - Parametrised (DATA_WIDTH, ADDR_WIDTH).
  - Two synchronous read ports and one write port with write enable.
  - Read-before-write on address collision; mini_alu_pipe's bypass covers that case.

Test Plan:
1. Reset, then "STO r1,5; STO r2,7; ADD r3,r1,r2; LED r3" -> oLed=12 two cycles after LED is fetched. ADD uses forwarded r2 with no stall.
2. "STO r1,3; SUB r4,r1,r1(src1=r1)" back-to-back, then "SMUL" of 0xFFFF*0x0002 -> r4=0. SMUL result 0xFFFE.
3. "STO r1,2; STO r2,2; BLE to 0x20; STO r5,0xAA at next address" -> STO r5 squashed. Next oIP=0x20. r5 unchanged (verify via later LED r5 after a known preset).
4. BEQ with unequal operands -> falls through, no bubble. JMP to 0xFF with IP_WIDTH=8 and IP wrap at 0xFF -> next sequential fetch is 0x00.
5. HLT at address 9 -> oHalted=1 next cycle. oIP stays 10 forever. LED unchanged despite LED op at address 10.
6. Drop iEnable for 3 cycles between dependent STO/ADD, and assert Reset during a taken JMP -> ADD result correct after resume. After reset, oIP=0, oLed=0, oHalted=0.
